// File: rtl/mips32_boot_pkg.sv
// Shared types and helpers for the MIPS32 boot loader.
// Holds the loader FSM states and the frame word-count rule.
package mips32_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_START
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // A COUNT byte of zero encodes a full 256-word frame.
  function automatic logic [8:0] frame_words(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/mips32_word_assembler.sv
// Big-endian byte-to-word assembler for the boot loader.
// o_word_ready pulses combinationally with the 4th byte of a word.
module mips32_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

  assign o_word       = {r_shift, i_byte};
  assign o_word_ready = i_en && (r_idx == 2'd3);

endmodule

// File: rtl/mips32_boot_loader.sv
// Framed byte-stream program loader for the MIPS32 core.
// Writes words from address 0, then releases the core on a good checksum.
module mips32_boot_loader
  import mips32_boot_pkg::*;
#(
  parameter int         ADDR_W   = 10,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              load_done,
  output logic              load_err
);

  state_t              r_state;
  state_t              w_next;
  logic [8:0]          r_left;
  logic [7:0]          r_chk;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_xfer;
  logic                w_hdr;
  logic                w_en;
  logic                w_match;
  logic [31:0]         w_word;
  logic                w_word_ready;

  assign rx_ready  = (r_state != ST_START);
  assign cpu_start = (r_state == ST_START);
  assign w_xfer    = rx_valid && rx_ready;
  assign w_hdr     = w_xfer && (r_state == ST_IDLE) && (rx_data == HDR_BYTE);
  assign w_en      = w_xfer && (r_state == ST_DATA);
  assign w_match   = (rx_data == r_chk);

  mips32_word_assembler u_asm (
    .clk          (clk1),
    .rst          (rst),
    .i_clr        (w_hdr),
    .i_en         (w_en),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_hdr) w_next = ST_COUNT;
      ST_COUNT: if (w_xfer) w_next = ST_DATA;
      ST_DATA:  if (w_word_ready && r_left == 9'd1) w_next = ST_CHECK;
      ST_CHECK: if (w_xfer) w_next = w_match ? ST_START : ST_IDLE;
      ST_START: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_left    <= '0;
      r_chk     <= '0;
      r_addr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_halt  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (w_hdr) begin
        cpu_halt  <= 1'b1;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        r_addr    <= '0;
        r_chk     <= '0;
        r_left    <= '0;
      end
      if (w_xfer && r_state == ST_COUNT) begin
        r_left <= frame_words(rx_data);
        r_chk  <= rx_data;
      end
      if (w_en) r_chk <= r_chk ^ rx_data;
      if (w_word_ready) begin
        mem_we    <= 1'b1;
        mem_addr  <= r_addr;
        mem_wdata <= w_word;
        r_addr    <= r_addr + 1'b1;
        r_left    <= r_left - 9'd1;
      end
      // A bad frame leaves the core halted; written words stay in memory.
      if (w_xfer && r_state == ST_CHECK) begin
        if (w_match) begin
          load_done <= 1'b1;
          cpu_halt  <= 1'b0;
        end else begin
          load_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Self-checking bench for mips32_boot_loader: table, directed and
// randomized frames checked against a frame-parsing reference model.
module tb_mips32_boot_loader;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_halt;
  logic          cpu_start;
  logic          load_done;
  logic          load_err;

  always #5 clk1 = ~clk1;

  mips32_boot_loader #(.ADDR_W(AW), .HDR_BYTE(8'hA5)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_halt  (cpu_halt),
    .cpu_start (cpu_start),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct {
    logic [31:0] word;
    logic        flip;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int starts = 0;
  int start_cyc = 0;
  logic [AW+31:0] got_w[$];
  int             got_c[$];
  int             hs_q[$];
  logic [AW+31:0] exp_w[$];
  int             exp_starts;
  logic           exp_done, exp_err, exp_halt;
  logic [7:0]     stream[$];
  logic [31:0]    words[$];

  always @(posedge clk1) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endfunction

  always @(negedge clk1) begin
    if (!rst) begin
      if (mem_we) begin
        got_w.push_back({mem_addr, mem_wdata});
        got_c.push_back(cyc);
      end
      if (cpu_start) begin
        starts++;
        start_cyc = cyc;
        check("halt_low_at_start", {63'd0, cpu_halt}, 64'd0);
      end
    end
  end

  // Reference: parse the byte stream as frames and list the writes it implies.
  function automatic void model();
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] wd;
    logic [AW-1:0] a;
    exp_w.delete();
    exp_starts = 0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_halt = 1'b1;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5) begin
        i++;
        continue;
      end
      exp_done = 1'b0;
      exp_err = 1'b0;
      exp_halt = 1'b1;
      i++;
      if (i >= stream.size()) return;
      n = (stream[i] == 8'd0) ? 256 : int'(stream[i]);
      x = stream[i];
      i++;
      for (int w = 0; w < n; w++) begin
        if (i + 4 > stream.size()) return;
        wd = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
        x = x ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
        a = AW'(w % (1 << AW));
        exp_w.push_back({a, wd});
        i += 4;
      end
      if (i >= stream.size()) return;
      if (stream[i] == x) begin
        exp_done = 1'b1;
        exp_halt = 1'b0;
        exp_starts++;
      end else begin
        exp_err = 1'b1;
      end
      i++;
    end
  endfunction

  task automatic add_frame(input int n, input logic flip);
    logic [7:0] c;
    logic [7:0] x;
    c = (n == 256) ? 8'd0 : 8'(n);
    stream.push_back(8'hA5);
    stream.push_back(c);
    x = c;
    for (int k = 0; k < n; k++) begin
      for (int b = 3; b >= 0; b--) begin
        stream.push_back(words[k][b*8 +: 8]);
        x = x ^ words[k][b*8 +: 8];
      end
    end
    stream.push_back(flip ? (x ^ 8'h01) : x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int tries;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk1);
      #1;
    end
    rx_valid = 1'b1;
    rx_data = b;
    tries = 0;
    forever begin
      rdy = rx_ready;
      @(posedge clk1);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 100) begin
        total++;
        $display("FAIL handshake_timeout: rx_ready stayed %0b, required 1", rx_ready);
        break;
      end
    end
    hs_q.push_back(cyc);
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int maxgap);
    hs_q.delete();
    for (int k = 0; k < stream.size(); k++)
      send_byte(stream[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic clear_mon();
    got_w.delete();
    got_c.delete();
    starts = 0;
  endtask

  task automatic compare_model(input string tag);
    int m;
    repeat (4) @(posedge clk1);
    #1;
    model();
    check({tag, "_nwrites"}, got_w.size(), exp_w.size());
    m = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int k = 0; k < m; k++)
      check($sformatf("%s_write%0d", tag, k), got_w[k], exp_w[k]);
    check({tag, "_done"}, load_done, exp_done);
    check({tag, "_err"}, load_err, exp_err);
    check({tag, "_starts"}, starts, exp_starts);
    check({tag, "_halt"}, cpu_halt, exp_halt);
  endtask

  // Write k must appear in the cycle after the 4th byte of word k.
  task automatic check_timing(input string tag, input int off, input int n);
    for (int k = 0; k < n && k < got_c.size(); k++)
      check($sformatf("%s_wlat%0d", tag, k), got_c[k], hs_q[off + 5 + 4*k]);
    if (starts > 0)
      check({tag, "_start_lat"}, start_cyc, hs_q[off + 2 + 4*n]);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'hA5A5A5A5, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'hDEADBEEF, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk1);
    #1;
    check("rst_ready", rx_ready, 1);
    check("rst_halt", cpu_halt, 1);
    check("rst_we", mem_we, 0);
    check("rst_start", cpu_start, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk1);
    #1;

    // Program frame, good checksum, back-to-back bytes
    words = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
              32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
              32'hfc000000};
    stream.delete();
    clear_mon();
    add_frame(9, 1'b0);
    send_stream(0);
    compare_model("prog");
    check_timing("prog", 0, 9);
    check("prog_done_const", load_done, 1);

    // Same frame, checksum bit 0 flipped
    stream.delete();
    clear_mon();
    add_frame(9, 1'b1);
    send_stream(0);
    compare_model("badchk");
    check("badchk_err_const", load_err, 1);
    check("badchk_nostart", starts, 0);

    // Garbage before header plus random valid gaps
    stream.delete();
    clear_mon();
    stream.push_back(8'h00);
    stream.push_back(8'h5A);
    stream.push_back(8'hFF);
    add_frame(9, 1'b0);
    send_stream(3);
    compare_model("gaps");
    check_timing("gaps", 3, 9);

    // Header value as payload in word 1
    words = '{32'h11223344, 32'ha5a5a5a5, 32'h55667788};
    stream.delete();
    clear_mon();
    add_frame(3, 1'b0);
    send_stream(0);
    compare_model("payhdr");

    // Table of single-word frames
    foreach (tbl[t]) begin
      words = '{tbl[t].word};
      stream.delete();
      clear_mon();
      add_frame(1, tbl[t].flip);
      send_stream(1);
      repeat (4) @(posedge clk1);
      #1;
      check($sformatf("tbl%0d_nwrites", t), got_w.size(), 1);
      if (got_w.size() > 0)
        check($sformatf("tbl%0d_write", t), got_w[0], {AW'(0), tbl[t].word});
      check($sformatf("tbl%0d_done", t), load_done, tbl[t].exp_done);
      check($sformatf("tbl%0d_err", t), load_err, tbl[t].exp_err);
      check($sformatf("tbl%0d_starts", t), starts, tbl[t].exp_done);
    end

    // Reset after 2 bytes of word 3
    words = '{32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
    stream.delete();
    add_frame(4, 1'b0);
    stream = stream[0:2+12+1];
    send_stream(0);
    rst = 1'b1;
    #1;
    check("midrst_halt", cpu_halt, 1);
    check("midrst_ready", rx_ready, 1);
    check("midrst_addr", mem_addr, 0);
    check("midrst_we", mem_we, 0);
    @(posedge clk1);
    #1;
    rst = 1'b0;
    words = '{32'h12345678};
    stream.delete();
    clear_mon();
    add_frame(1, 1'b0);
    send_stream(0);
    compare_model("postrst");
    check_timing("postrst", 0, 1);

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      int n;
      int g;
      n = (r == 7) ? 256 : int'($urandom_range(1, 6));
      words.delete();
      for (int k = 0; k < n; k++) begin
        logic [31:0] wd;
        wd = $urandom;
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 3) == 0) wd[b*8 +: 8] = 8'hA5;
        words.push_back(wd);
      end
      stream.delete();
      clear_mon();
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h3C;
        stream.push_back(gb);
      end
      add_frame(n, 1'($urandom_range(0, 1)));
      send_stream((r == 7) ? 0 : 2);
      compare_model($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
